// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: pipeline writeback vs. a buffered multi-cycle result.
// Optional starvation guard for the buffered result is enabled by defining WB_ARB_FAIRNESS_EN.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p_we,
  input  logic [AW-1:0]   p_rd,
  input  logic [XLEN-1:0] p_wd,
  output logic            p_stall,
  input  logic            m_valid,
  input  logic [AW-1:0]   m_rd,
  input  logic [XLEN-1:0] m_wd,
  output logic            m_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic            m_pend,
  output logic [AW-1:0]   m_pend_rd
);

  typedef enum logic {EMPTY, FULL} buf_state_e;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("regfile_wb_arbiter: STARVE_MAX must be at least 1");
  end

  buf_state_e      state_q, state_d;
  logic [AW-1:0]   buf_rd_q, buf_rd_d;
  logic [XLEN-1:0] buf_wd_q, buf_wd_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  logic p_req, m_req, buf_full, force_buf;

  // Writes to x0 are architecturally meaningless, so they never compete for the port.
  assign buf_full = (state_q == FULL);
  assign m_ready  = (state_q == EMPTY) && !reset;
  assign p_req    = p_we && (p_rd != '0);
  assign m_req    = m_valid && m_ready && (m_rd != '0);

`ifdef WB_ARB_FAIRNESS_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign force_buf = buf_full && (starve_q == SW'(STARVE_MAX));
  assign p_stall   = force_buf && p_req && !reset;

  // The buffer cannot be refilled while FULL, so staying FULL means it lost this cycle.
  always_comb begin
    starve_d = '0;
    if (buf_full && state_d == FULL) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_buf = 1'b0;
  assign p_stall   = 1'b0;
`endif

  // NOTE: every output of this block is given a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    buf_rd_d = buf_rd_q;
    buf_wd_d = buf_wd_q;
    rf_we_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_wd_d  = rf_wd_q;
    if (force_buf) begin
      rf_we_d = 1'b1;
      rf_rd_d = buf_rd_q;
      rf_wd_d = buf_wd_q;
      state_d = EMPTY;
    end else if (p_req) begin
      rf_we_d = 1'b1;
      rf_rd_d = p_rd;
      rf_wd_d = p_wd;
      // A younger pipeline write to the same register supersedes any older m result.
      if (buf_full && p_rd == buf_rd_q) state_d = EMPTY;
      if (m_req && m_rd != p_rd) begin
        state_d  = FULL;
        buf_rd_d = m_rd;
        buf_wd_d = m_wd;
      end
    end else if (buf_full) begin
      rf_we_d = 1'b1;
      rf_rd_d = buf_rd_q;
      rf_wd_d = buf_wd_q;
      state_d = EMPTY;
    end else if (m_req) begin
      rf_we_d = 1'b1;
      rf_rd_d = m_rd;
      rf_wd_d = m_wd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      buf_rd_q <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      state_q  <= state_d;
      buf_rd_q <= buf_rd_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // NOTE: buffer data is deliberately not reset; it is only ever read while state_q is FULL.
  always_ff @(posedge clk) begin
    buf_wd_q <= buf_wd_d;
  end

  assign rf_we     = rf_we_q;
  assign rf_rd     = rf_rd_q;
  assign rf_wd     = rf_wd_q;
  assign m_pend    = buf_full;
  assign m_pend_rd = buf_full ? buf_rd_q : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations follow WB_ARB_FAIRNESS_EN when defined.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            reset;
  logic            p_we;
  logic [AW-1:0]   p_rd;
  logic [XLEN-1:0] p_wd;
  logic            p_stall;
  logic            m_valid;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_wd;
  logic            m_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic            m_pend;
  logic [AW-1:0]   m_pend_rd;

  int errors = 0;
  int checks = 0;

`ifdef WB_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .p_we      (p_we),
    .p_rd      (p_rd),
    .p_wd      (p_wd),
    .p_stall   (p_stall),
    .m_valid   (m_valid),
    .m_rd      (m_rd),
    .m_wd      (m_wd),
    .m_ready   (m_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .m_pend    (m_pend),
    .m_pend_rd (m_pend_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; registered outputs are read there too.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [AW-1:0] prd, input logic [XLEN-1:0] pwd,
                       input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] mwd);
    p_we = pwe; p_rd = prd; p_wd = pwd;
    m_valid = mv; m_rd = mrd; m_wd = mwd;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick;
    tick;
    check("rst_rf_we",     32'(rf_we),     32'd0);
    check("rst_rf_rd",     32'(rf_rd),     32'd0);
    check("rst_rf_wd",     rf_wd,          32'd0);
    check("rst_m_pend",    32'(m_pend),    32'd0);
    check("rst_m_pend_rd", 32'(m_pend_rd), 32'd0);
    check("rst_m_ready",   32'(m_ready),   32'd0);
    check("rst_p_stall",   32'(p_stall),   32'd0);

    reset = 1'b0;
    #1;
    check("post_rst_m_ready", 32'(m_ready), 32'd1);

    // Pipeline-only write.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    tick;
    check("pipe_we", 32'(rf_we), 32'd1);
    check("pipe_rd", 32'(rf_rd), 32'd5);
    check("pipe_wd", rf_wd,      32'hDEADBEEF);

    // Pipeline write to x0 is a null request; rd/wd hold.
    drive(1, 0, 32'h1234, 0, 0, 0);
    tick;
    check("pipe_x0_we", 32'(rf_we), 32'd0);
    check("pipe_x0_rd", 32'(rf_rd), 32'd5);
    check("pipe_x0_wd", rf_wd,      32'hDEADBEEF);

    // Direct m grant while the pipeline is idle.
    drive(0, 0, 0, 1, 7, 32'h12);
    check("direct_m_ready", 32'(m_ready), 32'd1);
    tick;
    check("direct_we",     32'(rf_we),  32'd1);
    check("direct_rd",     32'(rf_rd),  32'd7);
    check("direct_wd",     rf_wd,       32'h12);
    check("direct_m_pend", 32'(m_pend), 32'd0);

    // m to x0 handshakes but is neither written nor buffered.
    drive(0, 0, 0, 1, 0, 32'h99);
    check("m_x0_ready", 32'(m_ready), 32'd1);
    tick;
    check("m_x0_we",   32'(rf_we),  32'd0);
    check("m_x0_pend", 32'(m_pend), 32'd0);

    // Collision: pipeline wins, m result parks, drains on the next idle cycle.
    drive(1, 3, 32'hA, 1, 9, 32'hB);
    tick;
    check("coll_rd",      32'(rf_rd),     32'd3);
    check("coll_wd",      rf_wd,          32'hA);
    check("coll_pend",    32'(m_pend),    32'd1);
    check("coll_pend_rd", 32'(m_pend_rd), 32'd9);
    drive(0, 0, 0, 0, 0, 0);
    check("coll_m_ready", 32'(m_ready), 32'd0);
    tick;
    check("drain_we",      32'(rf_we),   32'd1);
    check("drain_rd",      32'(rf_rd),   32'd9);
    check("drain_wd",      rf_wd,        32'hB);
    check("drain_pend",    32'(m_pend),  32'd0);
    check("drain_m_ready", 32'(m_ready), 32'd1);

    // Same-rd discard: buffered rd 4 is superseded by the pipeline write to rd 4.
    drive(1, 2, 32'h21, 1, 4, 32'h44);
    tick;
    check("disc_fill_pend_rd", 32'(m_pend_rd), 32'd4);
    drive(1, 4, 32'h55, 0, 0, 0);
    tick;
    check("disc_rd",   32'(rf_rd),  32'd4);
    check("disc_wd",   rf_wd,       32'h55);
    check("disc_pend", 32'(m_pend), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    check("disc_after_we", 32'(rf_we), 32'd0);
    check("disc_after_wd", rf_wd,      32'h55);

    // Same-cycle direct m to the pipeline's rd is dropped but still handshaken.
    drive(1, 6, 32'h66, 1, 6, 32'h77);
    check("samecyc_m_ready", 32'(m_ready), 32'd1);
    tick;
    check("samecyc_wd",   rf_wd,       32'h66);
    check("samecyc_pend", 32'(m_pend), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    check("samecyc_idle_we", 32'(rf_we), 32'd0);

    // Starvation: buffer FULL while the pipeline writes every cycle.
    drive(1, 1, 32'h100, 1, 8, 32'h800);
    tick;
    check("starve_fill_pend", 32'(m_pend), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      drive(1, AW'(10 + i), 32'(i), 0, 0, 0);
      check($sformatf("starve_c%0d_stall", i), 32'(p_stall), 32'd0);
      tick;
      check($sformatf("starve_c%0d_rd", i),   32'(rf_rd),  32'(10 + i));
      check($sformatf("starve_c%0d_pend", i), 32'(m_pend), 32'd1);
    end
    drive(1, 15, 32'h15, 0, 0, 0);
    check("starve_c5_stall", 32'(p_stall), FAIR ? 32'd1 : 32'd0);
    tick;
    check("starve_c5_rd",   32'(rf_rd),  FAIR ? 32'd8 : 32'd15);
    check("starve_c5_wd",   rf_wd,       FAIR ? 32'h800 : 32'h15);
    check("starve_c5_pend", 32'(m_pend), FAIR ? 32'd0 : 32'd1);
    check("starve_c6_stall", 32'(p_stall), 32'd0);
    tick;
    check("starve_c6_we",   32'(rf_we),  32'd1);
    check("starve_c6_rd",   32'(rf_rd),  32'd15);
    check("starve_c6_wd",   rf_wd,       32'h15);
    check("starve_c6_pend", 32'(m_pend), FAIR ? 32'd0 : 32'd1);

    // Reset mid-operation with the buffer FULL.
    drive(1, 1, 32'h1, 1, 12, 32'hC);
    tick;
    check("midrst_fill_pend", 32'(m_pend), 32'd1);
    reset = 1'b1;
    drive(1, 3, 32'h3, 0, 0, 0);
    tick;
    check("midrst_pend",    32'(m_pend),    32'd0);
    check("midrst_pend_rd", 32'(m_pend_rd), 32'd0);
    check("midrst_we",      32'(rf_we),     32'd0);
    check("midrst_m_ready", 32'(m_ready),   32'd0);
    check("midrst_p_stall", 32'(p_stall),   32'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("midrst_rel_m_ready", 32'(m_ready), 32'd1);
    tick;
    check("midrst_rel_we",   32'(rf_we),  32'd0);
    check("midrst_rel_pend", 32'(m_pend), 32'd0);
    drive(1, 2, 32'h2, 0, 0, 0);
    tick;
    check("first_grant_we", 32'(rf_we), 32'd1);
    check("first_grant_rd", 32'(rf_rd), 32'd2);
    check("first_grant_wd", rf_wd,      32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbiter and sequencer for the single write port of the 32x32 integer register file. It shares that port between two requesters: the pipeline writeback stage, and a multi-cycle execution unit (divider / long-latency load) that returns results out of band. A one-entry holding buffer parks the multi-cycle result until the port is free. It drives the register file's write-enable, destination and write-data inputs from registered outputs.

## Interface
- XLEN, 32, data width
- AW, 5, register index width
- STARVE_MAX, 4, consecutive lost cycles before forced grant (fairness build only)

- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- p_we  input  1  pipeline writeback request
- p_rd  input  AW  pipeline destination
- p_wd  input  XLEN  pipeline data
- p_stall  output  1  pipeline write not accepted this cycle; hold p_* stable
- m_valid  input  1  multi-cycle result valid
- m_rd  input  AW  multi-cycle destination
- m_wd  input  XLEN  multi-cycle data
- m_ready  output  1  multi-cycle result accepted when m_valid & m_ready
- rf_we  output  1  to register file write enable
- rf_rd  output  AW  to register file write index
- rf_wd  output  XLEN  to register file write data
- m_pend  output  1  holding buffer occupied (to hazard unit)
- m_pend_rd  output  AW  destination held in buffer

## Operation
- Requests to x0 are null:
  - p_we with p_rd==0 counts as no request.
  - An m handshake with m_rd==0 completes but is never buffered or written.
- Buffer FSM:
  - EMPTY: m_ready=1.
    - m_valid, pipeline requesting → capture m_* into buffer, go to FULL.
    - m_valid, pipeline idle → direct grant to m_*; stay EMPTY.
  - FULL: m_ready=0.
    - Granted → go to EMPTY.
    - m_ready stays 0 in the granting cycle, so there is no same-cycle refill.
- Grant priority:
  - forced buffer (fairness)
  - then pipeline
  - then buffer
  - then direct m.
- Same-rd conflict: pipeline granted with p_rd == m_pend_rd.
  - Buffered entry is discarded, since the younger pipeline result is final. The buffer goes to EMPTY.
  - Direct m with m_rd == p_rd in the same cycle is likewise dropped, but still handshaken.
- The winning request is registered onto rf_we/rf_rd/rf_wd. With no winner, rf_we=0 and rf_rd/rf_wd hold their previous values.
- m_pend = FULL state; m_pend_rd = buffered rd (0 when EMPTY).

## Timing
- Grant decision is combinational in cycle N. rf_* update at rising edge N+1. The register file commits on the falling edge of cycle N+1.
- p_stall and m_ready are combinational from state and inputs.
- Buffered result write latency:
  - minimum 1 cycle after capture when the pipeline is idle;
  - unbounded without fairness.
- Reset (synchronous, while high):
  - rf_we=0, rf_rd=0, rf_wd=0;
  - buffer EMPTY, m_pend=0, m_pend_rd=0;
  - m_ready=0, p_stall=0;
  - starve counter=0.
- Reset asserted mid-operation discards any buffered entry. The first grant is possible in the cycle after reset deasserts.

## Configuration
- Macro: WB_ARB_FAIRNESS_EN.
- Defined:
  - A starve counter counts consecutive cycles in which the buffer is FULL and not granted.
  - When the counter reaches STARVE_MAX, the next cycle forces a buffer grant and asserts p_stall if p_we with p_rd≠0. The counter then clears.
  - The counter also clears on any buffer grant or discard.
  - The pipeline must hold p_* while p_stall=1; the held write wins the following cycle.
- Undefined: counter logic is absent, p_stall is tied to 0, and the buffer waits until a pipeline-idle cycle.

## Test plan
- Pipeline only: p_we=1, p_rd=5, p_wd=0xDEADBEEF in cycle 0 → rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF at cycle 1; p_rd=0 → rf_we=0.
- Direct m: pipeline idle, m_valid=1, m_rd=7, m_wd=0x12 → m_ready=1, rf_* show 7/0x12 next cycle, m_pend stays 0.
- Collision: p_we (rd 3, 0xA) with m_valid (rd 9, 0xB) in cycle 0 → cycle 1 writes rd 3 and m_pend=1, m_pend_rd=9, m_ready=0. The pipeline is idle in cycle 1, so cycle 2 writes rd 9/0xB and m_pend returns to 0.
- Same-rd discard: buffer holds rd 4; pipeline writes rd 4 value 0x55 → rf writes 0x55, m_pend clears, rd 4 is never written with the buffered data.
- Fairness, STARVE_MAX=4, macro defined: buffer FULL and p_we every cycle → p_stall=1 in the 5th cycle, buffered write appears next edge, held pipeline write follows. Same stimulus with macro undefined → p_stall never asserts and the buffer stays FULL.
- Reset mid-operation: reset=1 with buffer FULL → next cycle m_pend=0, rf_we=0, m_ready=0; after release m_ready=1.
